// File: rtl/mont_pkg.sv
// mont_pkg: shared widths and FSM state encoding for the serial Montgomery multiplier.
package mont_pkg;
    localparam int MONT_W = 512;
    localparam int CNT_W  = 9;
    typedef enum logic [1:0] {IDLE, LOOP, SUB} state_t;
endpackage

// File: rtl/mont_iter.sv
// mont_iter: one radix-2 Montgomery step, c_next = (c + a_bit*b + q*m) >> 1.
module mont_iter
    import mont_pkg::*;
(
    input  logic [MONT_W+1:0] c,
    input  logic              a_bit,
    input  logic [MONT_W-1:0] b,
    input  logic [MONT_W-1:0] m,
    output logic [MONT_W+1:0] c_next
);
    logic [MONT_W+1:0] s1, s2;
    // add a_i*B, add M when the partial sum is odd so it becomes even, then halve
    always_comb begin
        s1     = c + (a_bit ? {2'b00, b} : '0);
        s2     = s1 + (s1[0] ? {2'b00, m} : '0);
        c_next = s2 >> 1;
    end
endmodule

// File: rtl/mont_mul_serial.sv
// mont_mul_serial: bit-serial Montgomery multiplier, result = A*B*2^-512 mod M, 513-cycle latency.
// Optional macro MONT_ABORT_EN: start during LOOP/SUB restarts with freshly latched operands.
module mont_mul_serial
    import mont_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [MONT_W-1:0] in_a,
    input  logic [MONT_W-1:0] in_b,
    input  logic [MONT_W-1:0] in_m,
    output logic [MONT_W-1:0] result,
    output logic              done
);
    state_t            state, state_nx;
    logic [MONT_W-1:0] a_r, b_r, m_r;
    logic [MONT_W+1:0] c, c_next;
    logic [CNT_W-1:0]  i;
    logic              load, step, fin;

    mont_iter u_iter (.c(c), .a_bit(a_r[i]), .b(b_r), .m(m_r), .c_next(c_next));

    // state register
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) state <= IDLE;
        else         state <= state_nx;

    // next state: a load always (re)enters LOOP, the last bit moves to SUB, SUB returns to IDLE
    always_comb begin
        state_nx = state;
        if (load)                        state_nx = LOOP;
        else if (state == LOOP && &i)    state_nx = SUB;
        else if (state == SUB)           state_nx = IDLE;
    end

    // control decode: when to latch operands, iterate, or finish
    always_comb begin
`ifdef MONT_ABORT_EN
        load = start;
`else
        load = start && state == IDLE;
`endif
        step = state == LOOP && !load;
        fin  = state == SUB && !load;
    end

    // operand latch, accumulator/counter update and held result
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            a_r    <= '0;
            b_r    <= '0;
            m_r    <= '0;
            c      <= '0;
            i      <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            done <= fin;
            if (load) begin
                a_r <= in_a;
                b_r <= in_b;
                m_r <= in_m;
                c   <= '0;
                i   <= '0;
            end else if (step) begin
                c <= c_next;
                i <= i + CNT_W'(1);
            end
            if (fin) result <= (c >= {2'b00, m_r}) ? c[MONT_W-1:0] - m_r : c[MONT_W-1:0];
        end
endmodule

// File: tb/tb_mont_mul_serial.sv
// tb_mont_mul_serial: directed vector table, corner sequences and randomized runs against a modular-arithmetic model.
module tb_mont_mul_serial;
    logic         clk = 1'b0, resetn = 1'b0, start = 1'b0, done;
    logic [511:0] in_a = '0, in_b = '0, in_m = '0, result, mx;
    int           checks = 0, errors = 0;

    typedef struct { logic [511:0] a, b, m, e; } vec_t;
    vec_t tbl[6];

    mont_mul_serial dut (.clk(clk), .resetn(resetn), .start(start), .in_a(in_a), .in_b(in_b),
                         .in_m(in_m), .result(result), .done(done));

    always #5 clk = ~clk;

    function automatic logic [511:0] rnd();
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    // A*B mod M, then multiply by the inverse of 2 modulo M, 512 times
    function automatic logic [511:0] ref_mont(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m);
        logic [1023:0] p;
        logic [512:0]  x;
        p = ({512'b0, a} * {512'b0, b}) % {512'b0, m};
        x = 513'(p);
        for (int k = 0; k < 512; k++) x = x[0] ? (x + {1'b0, m}) >> 1 : x >> 1;
        return x[511:0];
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic scramble();
        in_a = rnd();
        in_b = rnd();
        in_m = rnd();
    endtask

    task automatic launch(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m, input bit rel);
        @(negedge clk);
        in_a = a; in_b = b; in_m = m; start = 1'b1;
        if (rel) resetn = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_done(output int lat, output bit moved);
        logic [511:0] r0;
        r0 = result; lat = 0; moved = 1'b0;
        while (!done && lat < 700) begin
            @(posedge clk); #1;
            lat++;
            if (!done && result !== r0) moved = 1'b1;
        end
    endtask

    task automatic check_op(input string name, input logic [511:0] exp, input int exp_lat);
        int lat;
        bit moved;
        wait_done(lat, moved);
        chk({name, "_res"}, result, exp);
        chk({name, "_lat"}, 512'(lat), 512'(exp_lat));
        chk({name, "_hold"}, 512'(moved), 512'(0));
        @(posedge clk); #1;
        chk({name, "_pulse"}, 512'(done), 512'(0));
    endtask

    initial begin
        int           lat, cnt;
        bit           moved;
        logic [511:0] a, b, m;
        mx = '1;
        tbl[0] = '{512'd5, 512'd7, mx, 512'd35};
        tbl[1] = '{mx - 512'd1, mx - 512'd1, mx, 512'd1};
        tbl[2] = '{512'd1, 512'd1, mx, 512'd1};
        tbl[3] = '{512'd1 << 511, 512'd2, mx, 512'd1};
        tbl[4] = '{512'd3, 512'd5, 512'd7, 512'd2};
        tbl[5] = '{512'd1, 512'd1, 512'd13, 512'd3};

        #12;
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_result", result, 512'd0);

        for (int k = 0; k < 6; k++) begin
            launch(tbl[k].a, tbl[k].b, tbl[k].m, k == 0);
            check_op($sformatf("vec%0d", k), tbl[k].e, 513);
        end

        // start accepted in the done cycle
        launch(512'd0, mx - 512'd1, mx, 1'b0);
        wait_done(lat, moved);
        chk("b2b_first_res", result, 512'd0);
        chk("b2b_first_lat", 512'(lat), 512'(513));
        in_a = 512'd1; in_b = 512'd1; in_m = mx; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
        check_op("b2b_second", 512'd1, 513);

        // second start 100 edges into an operation
        launch(512'd5, 512'd7, mx, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        in_a = 512'd2; in_b = 512'd3; in_m = mx; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble();
`ifdef MONT_ABORT_EN
        check_op("restart", 512'd6, 513);
`else
        check_op("restart", 512'd35, 412);
`endif
        cnt = 0;
        repeat (200) begin @(posedge clk); #1; if (done) cnt++; end
        chk("restart_single_done", 512'(cnt), 512'(0));

        // reset in the middle of an operation
        launch(512'd5, 512'd7, mx, 1'b0);
        repeat (200) @(posedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_done", 512'(done), 512'(0));
        chk("midrst_result", result, 512'd0);
        @(negedge clk) resetn = 1'b1;
        cnt = 0;
        repeat (600) begin @(posedge clk); #1; if (done) cnt++; end
        chk("midrst_no_done", 512'(cnt), 512'(0));
        resetn = 1'b0;
        launch(512'd2, 512'd3, mx, 1'b1);
        check_op("post_rst", 512'd6, 513);

        for (int k = 0; k < 80; k++) begin
            m = rnd() >> $urandom_range(0, 509);
            m[0] = 1'b1;
            if (m == 512'd1) m = 512'd3;
            a = rnd() % m;
            b = rnd() % m;
            launch(a, b, m, 1'b0);
            check_op($sformatf("rand%0d", k), ref_mont(a, b, m), 513);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
